ap_ctrl_initiator: RTL and testbench
====================================

AP_CTRL_INITIATOR -- requirements
Module: ap_ctrl_initiator

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of transaction and cycle counters.
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum accepted-but-uncompleted transactions (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 1024, idle-cycle limit while transactions are outstanding.
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-005 clock  in  1  sole clock, all logic on posedge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  request to run a batch.
REQ-008 cmd_count  in  CNT_W  number of transactions in the batch.
REQ-009 cmd_ready  out  1  high only in IDLE.
REQ-010 cont_hold  in  1  testbench backpressure; forces ap_continue low.
REQ-011 ap_start  out  1  start to DUT.
REQ-012 ap_ready  in  1  DUT accepted current start.
REQ-013 ap_done  in  1  DUT transaction complete.
REQ-014 ap_continue  out  1  permission for DUT to retire a done.
REQ-015 busy  out  1  high in RUN or DRAIN.
REQ-016 finish  out  1  one-cycle pulse when batch completes.
REQ-017 error  out  1  sticky, high in ERROR.
REQ-018 issued, completed, total_cycles  out  CNT_W each  batch statistics.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, ERROR.
REQ-020 IDLE: cmd_valid && cmd_ready latches cmd_count, clears issued/completed/total_cycles, goes to RUN; cmd_count==0 instead pulses finish next cycle and stays IDLE.
REQ-021 Accept = ap_start && ap_ready; completion = ap_done && ap_continue.
REQ-022 ap_start SHALL rise only in RUN when issued < count and outstanding < MAX_OUT, and once high SHALL stay high until accepted.
REQ-023 ap_start SHALL drop the cycle after the accept that makes issued == count; otherwise it stays high while the REQ-022 conditions hold.
REQ-024 outstanding +1 on accept, -1 on completion, unchanged on both in the same cycle.
REQ-025 ap_continue = !cont_hold in RUN/DRAIN; 0 in IDLE/ERROR.
REQ-026 RUN -> DRAIN when issued == count; DRAIN -> IDLE with one-cycle finish when completed == count.
REQ-027 total_cycles SHALL increment every cycle in RUN/DRAIN and saturate at all-ones.
REQ-028 The watchdog counter SHALL clear on any completion or when outstanding == 0, and otherwise increment; reaching TIMEOUT enters ERROR.
REQ-029 ERROR SHALL drive ap_start=0, hold error=1 and stay until reset; cmd_valid is ignored.
REQ-030 A completion with outstanding == 0 SHALL enter ERROR (protocol violation).
REQ-031 Statistics SHALL hold final values in IDLE until the next accepted command.

Reset
REQ-032 On reset, state = IDLE; ap_start, ap_continue, busy, finish, error = 0; cmd_ready = 1 from the first cycle after reset.
REQ-033 On reset, all counters = 0; reset mid-batch abandons the batch with no finish pulse.

Structure
REQ-034 The state enum and default parameter constants SHALL live in shared package ap_ctrl_pkg.
REQ-035 The watchdog SHALL be the sub-module ap_ctrl_watchdog (clear, enable, timeout out).
REQ-036 Total RTL SHALL be 120-400 lines, fully synthesizable, no delays.

Verification
REQ-037 count=3, DUT ap_ready same cycle as start, ap_done 2 cycles later -> issued=3, completed=3, single finish pulse, error=0.
REQ-038 count=8, MAX_OUT=2, DUT done delayed 10 cycles -> outstanding never exceeds 2, ap_start held low while 2 outstanding.
REQ-039 count=4, cont_hold high 20 cycles mid-batch -> ap_continue=0 throughout, no completions counted, batch finishes after release.
REQ-040 count=0 -> finish pulse one cycle after handshake, ap_start never asserted.
REQ-041 DUT never asserts ap_done, TIMEOUT=16 -> error=1 after 16 cycles, ap_start=0, cmd_ready=0.
REQ-042 reset asserted at issued=2 of 5 -> next cycle all outputs at REQ-032/033 values, no finish pulse.

Source files
------------

// File: rtl/ap_ctrl_pkg.sv
// Shared state encoding and default parameters for the ap_ctrl initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_MAX_OUT = 4;
  localparam int unsigned DEF_TIMEOUT = 1024;

  // Outstanding count never exceeds 15, so four bits always suffice.
  localparam int unsigned OUT_W = 4;

endpackage

// File: rtl/ap_ctrl_watchdog.sv
// Idle-cycle watchdog: counts consecutive enabled, non-cleared cycles.
// Latency: timeout_o is combinational in the TIMEOUT-th consecutive counting cycle.
// Backpressure: none; clear_i restarts the count, enable_i low holds it at zero.
module ap_ctrl_watchdog
  import ap_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: zero when idle or cleared, otherwise step and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != W'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = enable_i && !clear_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/ap_ctrl_initiator.sv
// Batch initiator driving an ap_ctrl_chain style block (start/ready/done/continue).
// Latency: ap_start rises the cycle after the command handshake; finish one cycle after last completion.
// Backpressure: cmd_ready only in IDLE; ap_start held until ap_ready; cont_hold gates ap_continue.
module ap_ctrl_initiator
  import ap_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned MAX_OUT = DEF_MAX_OUT,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  input  logic             cont_hold,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic             error,
  output logic [CNT_W-1:0] issued,
  output logic [CNT_W-1:0] completed,
  output logic [CNT_W-1:0] total_cycles
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] completed_q, completed_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             start_q, start_d;
  logic             finish_q, finish_d;

  logic accept;
  logic complete;
  logic active;
  logic wd_timeout;

  assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign ap_continue = active && !cont_hold;
  assign accept      = start_q && ap_ready;
  assign complete    = ap_done && ap_continue;

  // Watchdog only runs while work is in flight and nothing retires.
  ap_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock_i   (clock),
    .reset_i   (reset),
    .clear_i   (complete || (out_q == '0)),
    .enable_i  (active),
    .timeout_o (wd_timeout)
  );

  // Next-state and counter logic for the batch FSM.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issued_d    = issued_q;
    completed_d = completed_q;
    total_d     = total_q;
    out_d       = out_q;
    finish_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          count_d     = cmd_count;
          issued_d    = '0;
          completed_d = '0;
          total_d     = '0;
          out_d       = '0;
          if (cmd_count == '0) begin
            finish_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (accept) issued_d = issued_q + 1'b1;
        if (complete) completed_d = completed_q + 1'b1;
        if (accept && !complete) begin
          out_d = out_q + 1'b1;
        end else if (!accept && complete && (out_q != '0)) begin
          out_d = out_q - 1'b1;
        end
        if (total_q != {CNT_W{1'b1}}) total_d = total_q + 1'b1;
        if ((state_q == ST_RUN) && (issued_d == count_q)) begin
          state_d = ST_DRAIN;
        end
        if ((state_q == ST_DRAIN) && (completed_d == count_q)) begin
          state_d  = ST_IDLE;
          finish_d = 1'b1;
        end
        // A retire with nothing in flight, or a stalled DUT, is fatal.
        if ((complete && (out_q == '0)) || wd_timeout) begin
          state_d  = ST_ERROR;
          finish_d = 1'b0;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
    // Start is recomputed from post-edge values; a pending start cannot lose its
    // conditions because issued is unchanged and outstanding can only fall.
    start_d = (state_d == ST_RUN) && (issued_d < count_d) && (out_d < OUT_W'(MAX_OUT));
  end

  // Single state register for the FSM and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      total_q     <= '0;
      out_q       <= '0;
      start_q     <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      total_q     <= total_d;
      out_q       <= out_d;
      start_q     <= start_d;
      finish_q    <= finish_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = active;
  assign error        = (state_q == ST_ERROR);
  assign ap_start     = start_q;
  assign finish       = finish_q;
  assign issued       = issued_q;
  assign completed    = completed_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_ap_ctrl_initiator.sv
// Testbench for ap_ctrl_initiator: random batches against a scoreboard and batch-level model.
// Latency: n/a.
// Backpressure: bench randomises ap_ready, done delay and cont_hold.
module tb_ap_ctrl_initiator;

  localparam int CNT_W      = 16;
  localparam int MAX_OUT    = 2;
  localparam int TIMEOUT    = 64;
  localparam int WD_TIMEOUT = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_ready;
  logic             cont_hold = 1'b0;
  logic             ap_start;
  logic             ap_ready = 1'b0;
  logic             ap_done = 1'b0;
  logic             ap_continue;
  logic             busy, finish, error;
  logic [CNT_W-1:0] issued, completed, total_cycles;

  logic             w_cmd_valid = 1'b0;
  logic [CNT_W-1:0] w_cmd_count = '0;
  logic             w_cmd_ready, w_ap_start, w_ap_continue, w_busy, w_finish, w_error;
  logic [CNT_W-1:0] w_issued, w_completed, w_total;

  always #5 clock = ~clock;

  ap_ctrl_initiator #(.CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_count(cmd_count),
    .cmd_ready(cmd_ready), .cont_hold(cont_hold), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .busy(busy), .finish(finish), .error(error),
    .issued(issued), .completed(completed), .total_cycles(total_cycles)
  );

  // Second instance: DUT that accepts but never completes, short watchdog.
  ap_ctrl_initiator #(.CNT_W(CNT_W), .TIMEOUT(WD_TIMEOUT)) dut_wd (
    .clock(clock), .reset(reset), .cmd_valid(w_cmd_valid), .cmd_count(w_cmd_count),
    .cmd_ready(w_cmd_ready), .cont_hold(1'b0), .ap_start(w_ap_start), .ap_ready(1'b1),
    .ap_done(1'b0), .ap_continue(w_ap_continue), .busy(w_busy), .finish(w_finish), .error(w_error),
    .issued(w_issued), .completed(w_completed), .total_cycles(w_total)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard entry: batch size and the cycle its command handshake was seen.
  typedef struct {
    int cnt;
    int hs;
  } exp_t;
  exp_t sb_q[$];

  // Batch-level reference state.
  int cyc = 0;
  int m_cnt = 0, m_iss = 0, m_cmp = 0, m_tot = 0, m_out_max = 0;
  bit m_active = 0;
  bit prev_wait = 0;
  bit acc_s = 0, cmp_s = 0, rst_s = 1;

  // Responder knobs.
  int rdy_pct = 100, dmin = 2, dmax = 2, hold_pct = 0;
  bit hold_force = 0;
  int pend[$];

  // Behavioural block-under-control: ready, done after a delay, random hold.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (rst_s) begin
      pend.delete();
    end else begin
      if (cmp_s && pend.size() > 0) void'(pend.pop_front());
      if (acc_s) pend.push_back(cyc + $urandom_range(dmin, dmax));
    end
    ap_done   = (pend.size() > 0) && (pend[0] <= cyc);
    ap_ready  = ($urandom_range(0, 99) < rdy_pct);
    cont_hold = hold_force || ($urandom_range(0, 99) < hold_pct);
  end

  // Monitor: per-cycle checks against the model, scoreboard pop on finish.
  always @(negedge clock) begin
    exp_t e;
    acc_s = 0;
    cmp_s = 0;
    rst_s = reset;
    if (reset) begin
      sb_q.delete();
      m_cnt = 0; m_iss = 0; m_cmp = 0; m_tot = 0;
      m_active = 0; prev_wait = 0;
    end else begin
      if (finish) begin
        m_active = 0;
        check("finish_pending", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("final_issued", issued, e.cnt);
          check("final_completed", completed, e.cnt);
          check("final_accepts", m_iss, e.cnt);
          check("final_total_cycles", total_cycles, m_tot);
          if (e.cnt == 0) check("zero_count_latency", cyc - e.hs, 1);
        end
      end
      check("busy", busy, m_active);
      check("cmd_ready", cmd_ready, !m_active);
      check("error", error, 0);
      check("ap_continue", ap_continue, m_active && !cont_hold);
      check("issued", issued, m_iss);
      check("completed", completed, m_cmp);
      check("total_cycles", total_cycles, m_tot);
      check("outstanding_le_max", (m_iss - m_cmp) <= MAX_OUT, 1);
      if (ap_start)
        check("start_allowed", m_active && (m_iss < m_cnt) && ((m_iss - m_cmp) < MAX_OUT), 1);
      if (prev_wait) check("start_held", ap_start, 1);
      prev_wait = ap_start && !ap_ready;
      acc_s = ap_start && ap_ready;
      cmp_s = ap_done && ap_continue;
      if (m_active) m_tot++;
      if (acc_s) m_iss++;
      if (cmp_s) m_cmp++;
      if ((m_iss - m_cmp) > m_out_max) m_out_max = m_iss - m_cmp;
      if (cmd_valid && cmd_ready) begin
        sb_q.push_back('{cnt: int'(cmd_count), hs: cyc});
        m_cnt = int'(cmd_count);
        m_iss = 0; m_cmp = 0; m_tot = 0;
        m_active = (cmd_count != '0);
      end
    end
  end

  task automatic issue(input int cnt);
    int waited;
    waited = 0;
    @(posedge clock); #1;
    cmd_count = CNT_W'(cnt);
    cmd_valid = 1'b1;
    @(negedge clock);
    while (!cmd_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("cmd_handshake", cmd_ready, 1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      n++;
    end while ((sb_q.size() != 0 || m_active) && n < 3000);
    check("batch_done", sb_q.size() + int'(m_active), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_ap_start"}, ap_start, 0);
    check({tag, "_ap_continue"}, ap_continue, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_issued"}, issued, 0);
    check({tag, "_completed"}, completed, 0);
    check({tag, "_total"}, total_cycles, 0);
  endtask

  initial begin
    int n, saved, t0, lat;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state("reset");
    check("wd_reset_cmd_ready", w_cmd_ready, 1);

    // Three transactions, ready with start, done two cycles later.
    rdy_pct = 100; dmin = 2; dmax = 2; hold_pct = 0;
    issue(3);
    wait_done();
    repeat (3) @(negedge clock);
    check("hold_issued_idle", issued, 3);
    check("hold_completed_idle", completed, 3);

    // Eight transactions with slow completions: outstanding caps at MAX_OUT.
    m_out_max = 0;
    dmin = 10; dmax = 10;
    issue(8);
    wait_done();
    check("max_outstanding", m_out_max, MAX_OUT);

    // Continue held for 20 cycles mid-batch.
    dmin = 2; dmax = 3;
    issue(4);
    n = 0;
    while (m_iss < 1 && n < 100) begin @(posedge clock); n++; end
    #1 hold_force = 1;
    @(negedge clock);
    saved = m_cmp;
    repeat (20) @(negedge clock);
    check("hold_no_completion", completed, saved);
    check("hold_continue_low", ap_continue, 0);
    @(posedge clock); #1 hold_force = 0;
    wait_done();
    check("hold_batch_completed", completed, 4);

    // Zero-length batch.
    issue(0);
    wait_done();

    // Randomised batches.
    for (int b = 0; b < 30; b++) begin
      rdy_pct  = $urandom_range(30, 100);
      dmin     = $urandom_range(1, 4);
      dmax     = dmin + $urandom_range(0, 8);
      hold_pct = $urandom_range(0, 40);
      issue($urandom_range(0, 12));
      wait_done();
    end

    // Reset in the middle of a five-transaction batch.
    rdy_pct = 100; dmin = 5; dmax = 6; hold_pct = 0;
    issue(5);
    n = 0;
    while (m_iss < 2 && n < 200) begin @(posedge clock); n++; end
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state("midreset");
    repeat (5) @(negedge clock);
    check("midreset_no_finish_busy", busy, 0);
    issue(2);
    wait_done();

    // Watchdog: second instance never sees ap_done.
    @(posedge clock); #1;
    w_cmd_count = CNT_W'(5);
    w_cmd_valid = 1'b1;
    t0 = cyc;
    @(posedge clock); #1;
    w_cmd_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (w_error) begin
        lat = cyc - t0;
        break;
      end
    end
    check("wd_error", w_error, 1);
    check("wd_latency_in_range", (lat >= WD_TIMEOUT) && (lat <= WD_TIMEOUT + 4), 1);
    check("wd_ap_start", w_ap_start, 0);
    check("wd_cmd_ready", w_cmd_ready, 0);
    check("wd_busy", w_busy, 0);
    check("wd_ap_continue", w_ap_continue, 0);
    @(posedge clock); #1 w_cmd_valid = 1'b1;
    repeat (5) @(negedge clock);
    check("wd_error_sticky", w_error, 1);
    check("wd_cmd_ignored_busy", w_busy, 0);
    check("wd_no_finish", w_finish, 0);
    @(posedge clock); #1 w_cmd_valid = 1'b0;

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
